// File: rtl/four_way_tcm_pkg.sv
// Shared types and geometry helpers for the four-way carry-less multiplier.
// FOUR_WAY_TCM_OUT_REG_EN adds the OUT state for the optional output stage.
package four_way_tcm_pkg;

  localparam int LIMBS = 4;
  localparam int NCOEF = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    COMB
`ifdef FOUR_WAY_TCM_OUT_REG_EN
    , OUT
`endif
  } state_e;

  typedef struct packed {
    int lw;
    int st;
  } geom_t;

  function automatic geom_t geom(int n, int d);
    geom_t g;
    g.lw = n / LIMBS;
    g.st = (n / LIMBS) / d;
    return g;
  endfunction

  function automatic bit cfg_ok(int n, int d);
    return (n % LIMBS == 0) && (d > 0) &&
           ((n / LIMBS) % d == 0);
  endfunction

endpackage

// File: rtl/four_way_tcm_mul_seq_mac.sv
// One limb-pair digit step: acc ^ ((b_limb * a_digit) << step*DIGIT)
// over GF(2)[x].
module gf2_digit_mac #(
  parameter int L     = 64,
  parameter int DIGIT = 8,
  parameter int CW    = 3
) (
  input  logic [L-1:0]     b_limb_i,
  input  logic [DIGIT-1:0] a_digit_i,
  input  logic [CW-1:0]    step_i,
  input  logic [2*L-2:0]   acc_i,
  output logic [2*L-2:0]   acc_o
);

  logic [2*L-2:0] pp;

  always_comb begin
    pp = '0;
    for (int t = 0; t < DIGIT; t++) begin
      if (a_digit_i[t]) begin
        pp = pp ^ ({{(L-1){1'b0}}, b_limb_i} << t);
      end
    end
    acc_o = acc_i ^ (pp << (32'(step_i) * DIGIT));
  end

endmodule

// File: rtl/four_way_tcm_mul_seq.sv
// Sequential four-way carry-less multiplier, digit-serial per limb.
// Define FOUR_WAY_TCM_OUT_REG_EN for an extra output register stage.
module four_way_tcm_mul_seq
  import four_way_tcm_pkg::*;
#(
  parameter int N     = 256,
  parameter int DIGIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam geom_t G  = geom(N, DIGIT);
  localparam int    L  = G.lw;
  localparam int    S  = G.st;
  localparam int    CW = (S > 1) ? $clog2(S) : 1;
  localparam int    AW = 2 * L - 1;

  if (!cfg_ok(N, DIGIT)) begin : g_cfg_err
    $error("four_way_tcm_mul_seq: N/4 must be a multiple of DIGIT");
  end

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   a_q, b_q, a_d;
  logic [AW-1:0]  acc_q [NCOEF];
  logic [AW-1:0]  acc_d [NCOEF];
  logic [AW-1:0]  mac_o [LIMBS][LIMBS];
  logic [2*N-1:0] c_d, c_q;
  logic           busy_q, done_q, accept;
`ifdef FOUR_WAY_TCM_OUT_REG_EN
  logic [2*N-1:0] res_q;
  localparam state_e LAST = OUT;
`else
  localparam state_e LAST = COMB;
`endif

  // Pairs with equal i+j form one XOR chain per coefficient.
  for (genvar i = 0; i < LIMBS; i++) begin : g_i
    for (genvar j = 0; j < LIMBS; j++) begin : g_j
      logic [AW-1:0] chain;
      if (i == 0 || j == LIMBS - 1) begin : g_head
        assign chain = acc_q[i+j];
      end else begin : g_link
        assign chain = mac_o[i-1][j+1];
      end
      gf2_digit_mac #(
        .L(L), .DIGIT(DIGIT), .CW(CW)
      ) u_mac (
        .b_limb_i (b_q[j*L +: L]),
        .a_digit_i(a_q[i*L +: DIGIT]),
        .step_i   (cnt_q),
        .acc_i    (chain),
        .acc_o    (mac_o[i][j])
      );
    end
    assign a_d[i*L +: L] = a_q[i*L +: L] >> DIGIT;
  end

  for (genvar k = 0; k < NCOEF; k++) begin : g_k
    localparam int I = (k < LIMBS) ? k : LIMBS - 1;
    assign acc_d[k] = mac_o[I][k-I];
  end

  always_comb begin
    c_d = '0;
    for (int k = 0; k < NCOEF; k++) begin
      c_d = c_d ^ ({{(2*N-AW){1'b0}}, acc_q[k]} << (k * L));
    end
  end

  assign accept = start && (state_q == IDLE || state_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NCOEF; k++) acc_q[k] <= '0;
`ifdef FOUR_WAY_TCM_OUT_REG_EN
      res_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ACC: begin
          a_q   <= a_d;
          cnt_q <= cnt_q + CW'(1);
          for (int k = 0; k < NCOEF; k++) acc_q[k] <= acc_d[k];
          if (cnt_q == CW'(S - 1)) state_q <= COMB;
        end
`ifdef FOUR_WAY_TCM_OUT_REG_EN
        COMB: begin
          res_q   <= c_d;
          state_q <= OUT;
        end
        OUT: begin
          c_q     <= res_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`else
        COMB: begin
          c_q     <= c_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`endif
        default: ;
      endcase
      // The finishing edge may also take the next job.
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= ACC;
        for (int k = 0; k < NCOEF; k++) acc_q[k] <= '0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: doc/four_way_tcm_mul_seq.md
# four_way_tcm_mul_seq

Parametrised sequential GF(2)[x] (carry-less) multiplier. Each operand is split into four limbs, and the seven limb-coefficient products are accumulated digit-serially over a shared counter, then recombined into one 2N-bit product. This block supersedes the fixed 256x256 free-running four-way multiplier. It adds configurable width and digit size, a start/busy/done handshake, operand capture and clean restart. It sits in the large-integer multiplier library as a drop-in core for binary-field arithmetic datapaths.

## Interface
- `N`, 256: operand width in bits. Must be a multiple of 4.
- `DIGIT`, 8: a-bits consumed per limb per cycle. Must divide `N/4`.
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `start`  in  1  request a multiplication; sampled only when idle.
- `a`  in  N  multiplicand; captured on an accepted start.
- `b`  in  N  multiplier; captured on an accepted start.
- `busy`  out  1  high while a job is in flight. Reset value 0.
- `done`  out  1  one-cycle pulse when `c` is updated. Reset value 0.
- `c`  out  2N  product; holds its value until the next `done`. Reset value 0.

## Operation
- L = N/4 is the limb width. Limbs: a0 = a[L-1:0] … a3 = a[N-1:3L]; b limbs likewise.
- Coefficient accumulators k = 0..6, each 2L-1 bits wide.
  - acc_k = XOR over i+j=k of ai·bj, where · is the carry-less product.
  - k=0 is a0b0; k=6 is a3b3.
- FSM states:
  - IDLE: start=1 captures a and b, clears all acc_k and the counter, and moves to ACC. start=0 stays in IDLE.
  - ACC: at count s, for every limb ai and digit bit t in 0..DIGIT-1, if ai[s·DIGIT+t]=1 then XOR (bj << (s·DIGIT+t)) into acc_(i+j) for all j. The counter increments each cycle. After S = L/DIGIT cycles the FSM moves to COMB.
  - COMB: c ← XOR over k of (acc_k << k·L), zero-extended to 2N. Bit 2N-1 is always 0. done pulses. Next state is IDLE.
- `start` while busy=1 is ignored. It is not queued, and the captured operands are unaffected.
- Operands are captured, so a and b may change freely after the accept edge.
- `busy` = (state != IDLE).
- Reset asserted mid-job aborts immediately:
  - state goes to IDLE; busy, done, c, counter and accumulators go to 0.
  - No done is produced for the aborted job.

## Timing
- Start accepted at edge E:
  - busy is high from E until the COMB edge.
  - Accumulation occurs on edges E+1..E+S.
  - The COMB edge is E+S+1. After it, c is new and done=1 for exactly one cycle, and busy is low.
- Latency from accept edge to done is S+1 cycles. For N=256 and DIGIT=8 this is 9 cycles.
- Back-to-back operation: start held high while done=1 is accepted on that same edge. Throughput is one job per S+1 cycles.
- Reset deassertion is synchronised externally. The first start is honoured on the first edge after release.

## Configuration
- `FOUR_WAY_TCM_OUT_REG_EN` defined:
  - adds one output register stage after COMB;
  - c and done appear one cycle later, so latency is S+2;
  - busy stays high through that extra cycle;
  - back-to-back accept moves to the cycle done is high.
- Undefined: timing is exactly as described above.
- The result value is identical in both builds.

## Structure
- Package `four_way_tcm_pkg` holds:
  - limb count 4 and coefficient count 7;
  - the FSM state enum (IDLE, ACC, COMB, plus OUT when the macro is enabled);
  - a function giving limb width and step count from N and DIGIT;
  - elaboration checks for N%4 and L%DIGIT.
- One sub-module, `gf2_digit_mac`, which computes acc ^ (b_limb · a_digit << offset) for one L x DIGIT carry-less partial product. It is instantiated 16 times, once per limb pair, feeding the 7 coefficient XOR trees.

## Test plan
All scenarios use N=256, DIGIT=8.
- a=1, b=1, start pulse -> done at 9 cycles, c=1, busy high for exactly 9 cycles.
- a=3, b=3 -> c=5 (carry-less); a=0xFF, b=0xFF -> c=0x5555.
- a=2^63, b=2^64 (cross-limb) -> c=2^127; a=2^255, b=2^255 -> c=2^510.
- 1000 random pairs against a bit-serial reference model, issued back-to-back with start held high -> every c matches and done has a 9-cycle period.
- start pulsed at cycle 3 of a job with different operands -> ignored; the first job's result is unchanged and there is no extra done.
- rst low at cycle 4 of a job -> busy=0, done=0, c=0 asynchronously. After release, a new job with a=5, b=7 gives c=0x1B.
